// File: rtl/dpmem_pkg.sv
// Shared constants and types for the byte-enable dual-port memory.
// Read-mode encodings and the clear/ready FSM state type.
package dpmem_pkg;

    localparam int MODE_WF = 0;
    localparam int MODE_RF = 1;
    localparam int MODE_NC = 2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

endpackage

// File: rtl/dpmem_be_outstage.sv
// Per-port output stage: optional extra output register plus val pipeline.
// Ports: clk, srst, d/v (first-stage data/update), q/qv (port do/val).
module dpmem_be_outstage
    import dpmem_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int OUTREG = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    input  logic             v,
    output logic [WIDTH-1:0] q,
    output logic             qv
);

    if (OUTREG != 0) begin : g_reg
        // Free-running stage: the first stage holds its data between
        // updates, so q stays stable without any enable here.
        always_ff @(posedge clk) begin
            if (srst) begin
                q  <= '0;
                qv <= 1'b0;
            end else begin
                q  <= d;
                qv <= v;
            end
        end
    end else begin : g_pass
        logic unused_pass;
        assign unused_pass = clk ^ srst;
        assign q  = d;
        assign qv = v;
    end

endmodule

// File: rtl/dpmem_be.sv
// True dual-port RAM, one clock, per-lane write enables and per-port modes.
// Ports: clk, srst, ena/enb, wea/web, addra/addrb, dia/dib, doa/dob,
// vala/valb, ready. Define DPMEM_CLEAR_ON_RESET_EN for a zeroing sweep.
module dpmem_be
    import dpmem_pkg::*;
#(
    parameter int DEPTH   = 10,
    parameter int WIDTH   = 32,
    parameter int BYTE    = 8,
    parameter int MODEA   = 0,
    parameter int MODEB   = 0,
    parameter int OUTREGA = 1,
    parameter int OUTREGB = 1,
    localparam int NBE    = WIDTH / BYTE
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             ena,
    input  logic             enb,
    input  logic [NBE-1:0]   wea,
    input  logic [NBE-1:0]   web,
    input  logic [DEPTH-1:0] addra,
    input  logic [DEPTH-1:0] addrb,
    input  logic [WIDTH-1:0] dia,
    input  logic [WIDTH-1:0] dib,
    output logic [WIDTH-1:0] doa,
    output logic [WIDTH-1:0] dob,
    output logic             vala,
    output logic             valb,
    output logic             ready
);

    logic [WIDTH-1:0] mem [0:2**DEPTH-1];

    state_t state;
`ifdef DPMEM_CLEAR_ON_RESET_EN
    logic [DEPTH-1:0] cnt;
`endif

    always_ff @(posedge clk) begin
        if (srst) begin
`ifdef DPMEM_CLEAR_ON_RESET_EN
            state <= ST_CLEAR;
            cnt   <= '0;
`else
            state <= ST_READY;
`endif
            ready <= 1'b0;
        end else begin
            unique case (state)
                ST_CLEAR: begin
`ifdef DPMEM_CLEAR_ON_RESET_EN
                    cnt <= cnt + DEPTH'(1);
                    if (cnt == '1) begin
                        state <= ST_READY;
                        ready <= 1'b1;
                    end
`else
                    state <= ST_READY;
                    ready <= 1'b1;
`endif
                end
                default: ready <= 1'b1;
            endcase
        end
    end

    logic           acca, accb, wra, wrb, same;
    logic [NBE-1:0] wa, wb;

    assign acca = ena & ready & ~srst;
    assign accb = enb & ready & ~srst;
    assign wa   = acca ? wea : '0;
    assign wb   = accb ? web : '0;
    assign wra  = |wa;
    assign wrb  = |wb;
    assign same = (addra == addrb);

    // Final word at each port's address after this cycle's writes:
    // A owns the lanes it writes, B fills only lanes A leaves alone.
    logic [WIDTH-1:0] olda, oldb, nxta, nxtb;

    always_comb begin
        olda = mem[addra];
        oldb = mem[addrb];
        nxta = olda;
        nxtb = oldb;
        for (int i = 0; i < NBE; i++) begin
            if (wa[i])
                nxta[i*BYTE +: BYTE] = dia[i*BYTE +: BYTE];
            else if (same && wb[i])
                nxta[i*BYTE +: BYTE] = dib[i*BYTE +: BYTE];
            if (same && wa[i])
                nxtb[i*BYTE +: BYTE] = dia[i*BYTE +: BYTE];
            else if (wb[i])
                nxtb[i*BYTE +: BYTE] = dib[i*BYTE +: BYTE];
        end
    end

    always_ff @(posedge clk) begin
        if (wrb)
            mem[addrb] <= nxtb;
        if (wra)
            mem[addra] <= nxta;
`ifdef DPMEM_CLEAR_ON_RESET_EN
        if (state == ST_CLEAR && !srst)
            mem[cnt] <= '0;
`endif
    end

    logic [WIDTH-1:0] rda, rdb;
    logic             rva, rvb;

    always_ff @(posedge clk) begin
        if (srst) begin
            rda <= '0;
            rva <= 1'b0;
        end else begin
            rva <= 1'b0;
            if (acca) begin
                if (!wra) begin
                    rda <= olda;
                    rva <= 1'b1;
                end else if (MODEA == MODE_WF) begin
                    rda <= nxta;
                    rva <= 1'b1;
                end else if (MODEA == MODE_RF) begin
                    rda <= olda;
                    rva <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdb <= '0;
            rvb <= 1'b0;
        end else begin
            rvb <= 1'b0;
            if (accb) begin
                if (!wrb) begin
                    rdb <= oldb;
                    rvb <= 1'b1;
                end else if (MODEB == MODE_WF) begin
                    rdb <= nxtb;
                    rvb <= 1'b1;
                end else if (MODEB == MODE_RF) begin
                    rdb <= oldb;
                    rvb <= 1'b1;
                end
            end
        end
    end

    dpmem_be_outstage #(.WIDTH(WIDTH), .OUTREG(OUTREGA)) u_outa (
        .clk  (clk),
        .srst (srst),
        .d    (rda),
        .v    (rva),
        .q    (doa),
        .qv   (vala)
    );

    dpmem_be_outstage #(.WIDTH(WIDTH), .OUTREG(OUTREGB)) u_outb (
        .clk  (clk),
        .srst (srst),
        .d    (rdb),
        .v    (rvb),
        .q    (dob),
        .qv   (valb)
    );

endmodule

// File: tb/tb_dpmem_be.sv
// Bench for dpmem_be: three instances sharing stimulus, checked against
// a word/lane-level memory model with per-port mode and latency.
module tb_dpmem_be;

`ifdef DPMEM_CLEAR_ON_RESET_EN
    localparam int CLEARN = 16;
`else
    localparam int CLEARN = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst, ena, enb;
    logic [3:0]  wea, web, addra, addrb;
    logic [31:0] dia, dib;
    logic [31:0] doa_w [3];
    logic [31:0] dob_w [3];
    logic        vala_w [3];
    logic        valb_w [3];
    logic        rdy_w [3];

    // u0: A write-first/2-cycle, B read-first/1-cycle
    dpmem_be #(.DEPTH(4), .WIDTH(32), .BYTE(8), .MODEA(0), .MODEB(1),
               .OUTREGA(1), .OUTREGB(0)) u0 (
        .clk(clk), .srst(srst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_w[0]), .dob(dob_w[0]), .vala(vala_w[0]), .valb(valb_w[0]),
        .ready(rdy_w[0]));

    // u1: A read-first/1-cycle, B write-first/2-cycle
    dpmem_be #(.DEPTH(4), .WIDTH(32), .BYTE(8), .MODEA(1), .MODEB(0),
               .OUTREGA(0), .OUTREGB(1)) u1 (
        .clk(clk), .srst(srst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_w[1]), .dob(dob_w[1]), .vala(vala_w[1]), .valb(valb_w[1]),
        .ready(rdy_w[1]));

    // u2: both ports no-change
    dpmem_be #(.DEPTH(4), .WIDTH(32), .BYTE(8), .MODEA(2), .MODEB(2),
               .OUTREGA(1), .OUTREGB(0)) u2 (
        .clk(clk), .srst(srst), .ena(ena), .enb(enb), .wea(wea), .web(web),
        .addra(addra), .addrb(addrb), .dia(dia), .dib(dib),
        .doa(doa_w[2]), .dob(dob_w[2]), .vala(vala_w[2]), .valb(valb_w[2]),
        .ready(rdy_w[2]));

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference model: port index p = 2*instance + (0 for A, 1 for B)
    logic [31:0] mm [16];
    int          mode_p [6] = '{0, 1, 1, 0, 2, 2};
    int          oreg_p [6] = '{1, 0, 0, 1, 1, 0};
    logic [31:0] st_d [6];
    logic [31:0] ex_d [6];
    bit          st_v [6];
    bit          ex_v [6];
    bit          m_rdy;
    int          left;

    function automatic logic [31:0] stored(input logic [3:0] ad,
                                           input bit aa, input bit ab);
        logic [31:0] w;
        w = mm[ad];
        for (int l = 0; l < 4; l++) begin
            if (ab && addrb == ad && web[l]) w[8*l +: 8] = dib[8*l +: 8];
            if (aa && addra == ad && wea[l]) w[8*l +: 8] = dia[8*l +: 8];
        end
        return w;
    endfunction

    task automatic cyc();
        bit          aa, ab, wrA, wrB, acc, wr;
        bit          ev_v [6];
        logic [31:0] ev_d [6];
        logic [31:0] wA, wB;
        logic [3:0]  ad;
        aa  = ena && m_rdy && !srst;
        ab  = enb && m_rdy && !srst;
        wrA = aa && (wea != 4'h0);
        wrB = ab && (web != 4'h0);
        for (int p = 0; p < 6; p++) begin
            acc = (p % 2 == 0) ? aa : ab;
            wr  = (p % 2 == 0) ? wrA : wrB;
            ad  = (p % 2 == 0) ? addra : addrb;
            ev_v[p] = 1'b0;
            ev_d[p] = '0;
            if (acc) begin
                if (!wr) begin
                    ev_v[p] = 1'b1; ev_d[p] = mm[ad];
                end else if (mode_p[p] == 0) begin
                    ev_v[p] = 1'b1; ev_d[p] = stored(ad, aa, ab);
                end else if (mode_p[p] == 1) begin
                    ev_v[p] = 1'b1; ev_d[p] = mm[ad];
                end
            end
        end
        wA = stored(addra, aa, ab);
        wB = stored(addrb, aa, ab);
        @(posedge clk);
        if (srst) begin
            for (int p = 0; p < 6; p++) begin
                st_v[p] = 1'b0; st_d[p] = '0;
                ex_v[p] = 1'b0; ex_d[p] = '0;
            end
            m_rdy = 1'b0;
            left  = CLEARN;
        end else begin
            for (int p = 0; p < 6; p++) begin
                if (oreg_p[p] != 0) begin
                    ex_v[p] = st_v[p];
                    ex_d[p] = st_d[p];
                    st_v[p] = ev_v[p];
                    if (ev_v[p]) st_d[p] = ev_d[p];
                end else begin
                    ex_v[p] = ev_v[p];
                    if (ev_v[p]) ex_d[p] = ev_d[p];
                end
            end
            if (wrB) mm[addrb] = wB;
            if (wrA) mm[addra] = wA;
            if (left > 0) begin
                mm[CLEARN-left] = '0;
                left--;
            end
            m_rdy = (left == 0);
        end
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("doa%0d", d), doa_w[d], ex_d[2*d]);
            chk($sformatf("dob%0d", d), dob_w[d], ex_d[2*d+1]);
            chk($sformatf("vala%0d", d), 32'(vala_w[d]), 32'(ex_v[2*d]));
            chk($sformatf("valb%0d", d), 32'(valb_w[d]), 32'(ex_v[2*d+1]));
            chk($sformatf("ready%0d", d), 32'(rdy_w[d]), 32'(m_rdy));
        end
    endtask

    task automatic setA(input bit en, input logic [3:0] we,
                        input logic [3:0] ad, input logic [31:0] d);
        ena = en; wea = we; addra = ad; dia = d;
    endtask

    task automatic setB(input bit en, input logic [3:0] we,
                        input logic [3:0] ad, input logic [31:0] d);
        enb = en; web = we; addrb = ad; dib = d;
    endtask

    task automatic idle();
        setA(1'b0, 4'h0, 4'h0, 32'h0);
        setB(1'b0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        srst  = 1'b1;
        idle();
        m_rdy = 1'b0;
        left  = CLEARN;
        for (int p = 0; p < 6; p++) begin
            st_d[p] = '0; ex_d[p] = '0;
        end
        for (int i = 0; i < 16; i++) mm[i] = '0;

        repeat (3) cyc();
        srst = 1'b0;

`ifdef DPMEM_CLEAR_ON_RESET_EN
        for (int i = 0; i < 5; i++) begin
            setA(1'b1, 4'hF, 4'(i), $urandom);
            setB(1'b1, 4'hF, 4'(i + 8), $urandom);
            cyc();
            chk("clr_early_rdy", 32'(rdy_w[0]), 32'd0);
            chk("clr_no_val", 32'(vala_w[1]), 32'd0);
        end
        srst = 1'b1;
        cyc();
        srst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            setA(1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom);
            setB(1'b1, 4'hF, 4'($urandom_range(0, 15)), $urandom);
            cyc();
            chk("clr_count", 32'(rdy_w[1]), (i == 15) ? 32'd1 : 32'd0);
        end
        for (int a = 0; a < 16; a++) begin
            setA(1'b1, 4'h0, 4'(a), 32'h0);
            setB(1'b1, 4'h0, 4'(15 - a), 32'h0);
            cyc();
            chk("clr_zero", doa_w[1], 32'h0);
        end
`else
        cyc();
        chk("rdy_first", 32'(rdy_w[0]), 32'd1);
`endif

        for (int i = 0; i < 8; i++) begin
            setA(1'b1, 4'hF, 4'(i), $urandom);
            setB(1'b1, 4'hF, 4'(i + 8), $urandom);
            cyc();
        end

        // lane write
        idle();
        setA(1'b1, 4'hF, 4'd3, 32'hAABBCCDD); cyc();
        setA(1'b1, 4'b0010, 4'd3, 32'h11223344); cyc();
        setA(1'b1, 4'h0, 4'd3, 32'h0); cyc();
        chk("lane_u1", doa_w[1], 32'hAABB33DD);
        idle(); cyc();
        chk("lane_u0", doa_w[0], 32'hAABB33DD);
        chk("lane_u0_val", 32'(vala_w[0]), 32'd1);

        // modes
        setA(1'b1, 4'hF, 4'd1, 32'h9); cyc();
        setA(1'b1, 4'hF, 4'd1, 32'h5); cyc();
        chk("mode_rf", doa_w[1], 32'h9);
        idle(); cyc();
        chk("mode_wf", doa_w[0], 32'h5);
        chk("mode_nc_val", 32'(vala_w[2]), 32'd0);

        // collision
        setA(1'b1, 4'b0011, 4'd5, 32'h000000AA);
        setB(1'b1, 4'b1111, 4'd5, 32'h12345678); cyc();
        idle();
        setA(1'b1, 4'h0, 4'd5, 32'h0); cyc();
        chk("collide", doa_w[1], 32'h123400AA);
        chk("collide_b_wf", dob_w[1], 32'h123400AA);

        // cross-port read during write
        idle();
        setA(1'b1, 4'hF, 4'd2, 32'h7); cyc();
        setA(1'b1, 4'hF, 4'd2, 32'h8);
        setB(1'b1, 4'h0, 4'd2, 32'h0); cyc();
        chk("xport_old", dob_w[0], 32'h7);
        setA(1'b0, 4'h0, 4'd0, 32'h0); cyc();
        chk("xport_new", dob_w[0], 32'h8);

        // randomized traffic
        repeat (400) begin
            srst = ($urandom_range(0, 99) == 0);
            setA(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 4'($urandom), $urandom);
            setB(1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
                 ($urandom_range(0, 1) == 0) ? addra : 4'($urandom),
                 $urandom);
            cyc();
        end
        srst = 1'b0;
        idle();
        repeat (3) cyc();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
